keypad_cmd_encoder: RTL and testbench

- Upstream stage of calc_top: scans a 4x4 matrix keypad, debounces it and converts each accepted keypress into the 4-bit cmd code that calc_top consumes.
- Each press produces one cmd code held for a fixed number of cycles; otherwise cmd rests at the idle code 4'b1111.
- Held keys do not auto-repeat; a new press requires a debounced release first.

---
 rtl/keypad_cmd_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_cmd_encoder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_cmd_encoder.sv
`timescale 1ns/1ps
// Scans a 4x4 active-low keypad, debounces whole-matrix scans and turns each
// accepted press into one registered cmd code; held keys never auto-repeat.
module keypad_cmd_encoder #(
  parameter int SCAN_CYCLES    = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int HOLD_CYCLES    = 10
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_down
);
  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    NO_CMD     = 4'b1111;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;

  logic [3:0]    cols_meta, cols_sync;
  logic [1:0]    row_idx;
  logic [DW-1:0] dwell;
  logic [11:0]   press_acc;
  logic          sample, scan_done;
  logic [15:0]   scan_vec;
  logic [4:0]    n_pressed;
  logic [3:0]    key_idx;
  logic          any_pressed, single_key;
  logic [3:0]    key_cmd;

  state_t        state, state_n;
  logic [3:0]    cand, cand_n;
  logic [CW-1:0] deb_cnt, deb_n;
  logic [CW-1:0] rel_cnt, rel_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0]    cmd_n;
  logic          vld_n, kd_n;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'd1;
      4'd1:    key_code = 4'd2;
      4'd2:    key_code = 4'd3;
      4'd3:    key_code = 4'b1010;
      4'd4:    key_code = 4'd4;
      4'd5:    key_code = 4'd5;
      4'd6:    key_code = 4'd6;
      4'd7:    key_code = 4'b1011;
      4'd8:    key_code = 4'd7;
      4'd9:    key_code = 4'd8;
      4'd10:   key_code = 4'd9;
      4'd11:   key_code = 4'b1100;
      4'd12:   key_code = 4'b1101;
      4'd13:   key_code = 4'd0;
      4'd14:   key_code = 4'b1110;
      default: key_code = NO_CMD;
    endcase
  endfunction

  assign sample    = (dwell == DWELL_LAST);
  assign scan_done = sample && (row_idx == 2'd3);
  // Row 3 is still on the synchronizer when the scan completes, so it joins live.
  assign scan_vec  = {~cols_sync, press_acc};

  always_comb begin
    n_pressed = '0;
    key_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_vec[i]) begin
        n_pressed = n_pressed + 5'd1;
        key_idx   = 4'(i);
      end
    end
  end

  assign any_pressed = |scan_vec;
  assign single_key  = (n_pressed == 5'd1) && (key_idx != 4'd15);
  assign key_cmd     = key_code(key_idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cols_meta <= 4'b1111;
      cols_sync <= 4'b1111;
      row_idx   <= 2'd0;
      dwell     <= '0;
      rows      <= 4'b1110;
      press_acc <= '0;
    end else begin
      cols_meta <= cols;
      cols_sync <= cols_meta;
      if (sample) begin
        dwell   <= '0;
        row_idx <= row_idx + 2'd1;
        rows    <= ~(4'b0001 << (row_idx + 2'd1));
        case (row_idx)
          2'd0:    press_acc[3:0]  <= ~cols_sync;
          2'd1:    press_acc[7:4]  <= ~cols_sync;
          2'd2:    press_acc[11:8] <= ~cols_sync;
          default: ;
        endcase
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    deb_n   = deb_cnt;
    rel_n   = rel_cnt;
    hold_n  = hold_cnt;
    cmd_n   = cmd;
    vld_n   = 1'b0;
    kd_n    = key_down;
    case (state)
      IDLE: begin
        if (scan_done && single_key) begin
          if (DEBOUNCE_SCANS == 1) begin
            state_n = EMIT;
            cmd_n   = key_cmd;
            vld_n   = 1'b1;
            kd_n    = 1'b1;
            hold_n  = '0;
          end else begin
            state_n = DEBOUNCE;
            cand_n  = key_cmd;
            deb_n   = CW'(1);
          end
        end
      end
      DEBOUNCE: begin
        if (scan_done) begin
          if (!single_key) begin
            state_n = IDLE;
          end else if (key_cmd != cand) begin
            cand_n = key_cmd;
            deb_n  = CW'(1);
          end else if (deb_cnt == DEB_LAST) begin
            state_n = EMIT;
            cmd_n   = cand;
            vld_n   = 1'b1;
            kd_n    = 1'b1;
            hold_n  = '0;
          end else begin
            deb_n = deb_cnt + 1'b1;
          end
        end
      end
      EMIT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = RELEASE;
          cmd_n   = NO_CMD;
          rel_n   = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      RELEASE: begin
        // The unused key position still blocks release, unlike in IDLE.
        if (scan_done) begin
          if (any_pressed) begin
            rel_n = '0;
          end else if (rel_cnt == DEB_LAST) begin
            state_n = IDLE;
            kd_n    = 1'b0;
            rel_n   = '0;
          end else begin
            rel_n = rel_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      hold_cnt  <= '0;
      cmd       <= NO_CMD;
      cmd_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      deb_cnt   <= deb_n;
      rel_cnt   <= rel_n;
      hold_cnt  <= hold_n;
      cmd       <= cmd_n;
      cmd_valid <= vld_n;
      key_down  <= kd_n;
    end
  end
endmodule

// File: tb/tb_keypad_cmd_encoder.sv
`timescale 1ns/1ps
// Bench for keypad_cmd_encoder: a keypad model drives two instances (default
// and fast parameters); emissions are compared with a key-level model.
module tb_keypad_cmd_encoder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  rows0, cols0, cmd0, rows1, cols1, cmd1;
  logic        cmd_valid0, key_down0, cmd_valid1, key_down1;
  logic [15:0] keys0 = '0, keys1 = '0;
  int tests = 0, fails = 0;

  keypad_cmd_encoder dut0 (
    .clock(clock), .reset(reset), .rows(rows0), .cols(cols0),
    .cmd(cmd0), .cmd_valid(cmd_valid0), .key_down(key_down0));

  keypad_cmd_encoder #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(1), .HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .rows(rows1), .cols(cols1),
    .cmd(cmd1), .cmd_valid(cmd_valid1), .key_down(key_down1));

  // Passive matrix: a column reads low when a pressed key sits on the driven row.
  function automatic logic [3:0] matrix(input logic [3:0] r, input logic [15:0] k);
    logic [3:0] c;
    c = 4'b1111;
    for (int i = 0; i < 16; i++)
      if (!r[i / 4] && k[i]) c[i % 4] = 1'b0;
    return c;
  endfunction
  assign cols0 = matrix(rows0, keys0);
  assign cols1 = matrix(rows1, keys1);

  // Reference: label printed on the key at row r, column c.
  function automatic int model_code(input int idx);
    int r, c;
    r = idx / 4;
    c = idx % 4;
    if (r < 3 && c < 3) return r * 3 + c + 1;
    if (r < 3) return 10 + r;
    case (c)
      0: return 13;
      1: return 0;
      2: return 14;
      default: return -1;
    endcase
  endfunction

  int codes0[$];
  int runs0[$];
  int vld0 = 0, bad0 = 0, run0 = 0;
  logic [3:0] prev0 = 4'b1111;
  always @(negedge clock) begin
    if (cmd_valid0) begin
      vld0++;
      codes0.push_back(int'(cmd0));
      if (prev0 != 4'b1111 || cmd0 == 4'b1111) bad0++;
    end else if (prev0 == 4'b1111 && cmd0 != 4'b1111) begin
      bad0++;
    end
    if (cmd0 != 4'b1111) run0++;
    else if (run0 != 0) begin
      runs0.push_back(run0);
      run0 = 0;
    end
    prev0 = cmd0;
  end

  int vld1 = 0, run1 = 0, last_run1 = 0, last_code1 = -1;
  always @(negedge clock) begin
    if (cmd_valid1) begin
      vld1++;
      last_code1 = int'(cmd1);
    end
    if (cmd1 != 4'b1111) run1++;
    else if (run1 != 0) begin
      last_run1 = run1;
      run1 = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Returns just after the edge where row 0 is driven again (start of a scan).
  task automatic wait_scan();
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = rows0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clock); #1;
      if (rows0 == 4'b1110 && prev != 4'b1110) ok = 1'b1;
      prev = rows0;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL scan_start: rows=%b never returned to 1110", rows0);
    end
  endtask

  task automatic scans(input int n);
    repeat (n) wait_scan();
  endtask

  task automatic test_reset();
    keys0 = '0; keys1 = '0;
    #2 reset = 1'b1;
    #1;
    tests++; if (rows0 !== 4'b1110) begin fails++; $display("FAIL reset_rows: got %b want 1110", rows0); end
    tests++; if (cmd0 !== 4'b1111) begin fails++; $display("FAIL reset_cmd: got %b want 1111", cmd0); end
    tests++; if (cmd_valid0 !== 1'b0 || key_down0 !== 1'b0) begin
      fails++; $display("FAIL reset_flags: valid=%b key_down=%b want 0 0", cmd_valid0, key_down0); end
    tests++; if (rows1 !== 4'b1110 || cmd1 !== 4'b1111) begin
      fails++; $display("FAIL reset_fast: rows=%b cmd=%b want 1110 1111", rows1, cmd1); end
    @(negedge clock); reset = 1'b0;
    tick(100);
    tests++; if (vld0 != 0 || key_down0 !== 1'b0) begin
      fails++; $display("FAIL idle_no_press: pulses=%0d key_down=%b want 0 0", vld0, key_down0); end
  endtask

  task automatic test_clean_press();
    int cb, rb, vb, bb, lat;
    bit got;
    cb = codes0.size(); rb = runs0.size(); vb = vld0; bb = bad0;
    wait_scan();
    keys0 = 16'h0002;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clock); #1; lat++;
      if (cmd_valid0) got = 1'b1;
    end
    tests++; if (!got || lat < 48 || lat > 49) begin
      fails++; $display("FAIL press_latency: got %0d cycles (seen=%0d) want 48..49", lat, got); end
    scans(9);
    tests++; if (key_down0 !== 1'b1) begin fails++; $display("FAIL key_down_held: got %b want 1", key_down0); end
    keys0 = '0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      @(posedge clock); #1; lat++;
      if (key_down0 === 1'b0) got = 1'b1;
    end
    tests++; if (!got || lat < 48 || lat > 49) begin
      fails++; $display("FAIL release_latency: got %0d cycles (seen=%0d) want 48..49", lat, got); end
    tick(5);
    tests++; if (vld0 - vb != 1 || codes0.size() - cb != 1 || codes0[cb] != 2) begin
      fails++; $display("FAIL clean_code: pulses=%0d first=%0d want 1 pulse of 2", vld0 - vb,
                        (codes0.size() > cb) ? codes0[cb] : -1); end
    tests++; if (runs0.size() - rb != 1 || runs0[rb] != 10) begin
      fails++; $display("FAIL clean_hold: runs=%0d len=%0d want 1 run of 10", runs0.size() - rb,
                        (runs0.size() > rb) ? runs0[rb] : -1); end
    tests++; if (bad0 != bb) begin fails++; $display("FAIL clean_valid_align: bad=%0d want 0", bad0 - bb); end
  endtask

  task automatic test_bounce();
    int cb, vb;
    cb = codes0.size(); vb = vld0;
    wait_scan();
    keys0 = 16'h0010; wait_scan();
    keys0 = '0;       wait_scan();
    keys0 = 16'h0010; scans(2); tick(3);
    tests++; if (vld0 != vb) begin fails++; $display("FAIL bounce_early: pulses=%0d want 0", vld0 - vb); end
    wait_scan(); tick(3);
    tests++; if (vld0 - vb != 1 || codes0.size() <= cb || codes0[cb] != 4) begin
      fails++; $display("FAIL bounce_code: pulses=%0d first=%0d want 1 pulse of 4", vld0 - vb,
                        (codes0.size() > cb) ? codes0[cb] : -1); end
    keys0 = '0; scans(6);
  endtask

  task automatic test_ghost();
    int cb, vb;
    cb = codes0.size(); vb = vld0;
    wait_scan();
    keys0 = 16'h0011; scans(10); tick(3);
    tests++; if (vld0 != vb) begin fails++; $display("FAIL ghost_multi: pulses=%0d want 0", vld0 - vb); end
    keys0 = 16'h0001; scans(2); tick(3);
    tests++; if (vld0 != vb) begin fails++; $display("FAIL ghost_early: pulses=%0d want 0", vld0 - vb); end
    wait_scan(); tick(3);
    tests++; if (vld0 - vb != 1 || codes0.size() <= cb || codes0[cb] != 1) begin
      fails++; $display("FAIL ghost_code: pulses=%0d first=%0d want 1 pulse of 1", vld0 - vb,
                        (codes0.size() > cb) ? codes0[cb] : -1); end
    keys0 = '0; scans(6);
  endtask

  task automatic test_sequence();
    int seq[6] = '{0, 1, 2, 3, 0, 14};
    int cb, rb, vb, bb;
    cb = codes0.size(); rb = runs0.size(); vb = vld0; bb = bad0;
    foreach (seq[k]) begin
      wait_scan();
      keys0 = 16'(1) << seq[k]; scans(6);
      keys0 = '0;               scans(6);
    end
    tick(5);
    tests++; if (vld0 - vb != 6 || codes0.size() - cb != 6) begin
      fails++; $display("FAIL seq_count: pulses=%0d want 6", vld0 - vb); end
    foreach (seq[k]) begin
      tests++;
      if (codes0.size() <= cb + k || codes0[cb + k] != model_code(seq[k])) begin
        fails++; $display("FAIL seq_code[%0d]: got %0d want %0d", k,
                          (codes0.size() > cb + k) ? codes0[cb + k] : -1, model_code(seq[k])); end
    end
    for (int k = rb; k < runs0.size(); k++) begin
      tests++; if (runs0[k] != 10) begin fails++; $display("FAIL seq_hold[%0d]: got %0d want 10", k - rb, runs0[k]); end
    end
    tests++; if (bad0 != bb) begin fails++; $display("FAIL seq_valid_align: bad=%0d want 0", bad0 - bb); end
  endtask

  task automatic test_boundary();
    int cb, vb;
    vb = vld0;
    wait_scan();
    keys0 = 16'h8000; scans(8); tick(3);
    tests++; if (vld0 != vb || key_down0 !== 1'b0) begin
      fails++; $display("FAIL unused_key: pulses=%0d key_down=%b want 0 0", vld0 - vb, key_down0); end
    keys0 = '0; scans(4);
    cb = codes0.size(); vb = vld0;
    keys0 = 16'h0400; scans(5);
    keys0 = '0;       scans(2);
    keys0 = 16'h0400; scans(5);
    keys0 = '0;       scans(6);
    tests++; if (vld0 - vb != 1 || codes0.size() <= cb || codes0[cb] != 9) begin
      fails++; $display("FAIL short_release: pulses=%0d first=%0d want 1 pulse of 9", vld0 - vb,
                        (codes0.size() > cb) ? codes0[cb] : -1); end
  endtask

  task automatic test_fast_params();
    int lat, vb;
    bit got;
    vb = vld1;
    wait_scan();
    keys1 = 16'h0200;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock); #1; lat++;
      if (cmd_valid1) got = 1'b1;
    end
    tests++; if (!got || lat < 16 || lat > 17) begin
      fails++; $display("FAIL fast_latency: got %0d cycles (seen=%0d) want 16..17", lat, got); end
    tick(4);
    tests++; if (vld1 - vb != 1 || last_code1 != 8 || last_run1 != 1) begin
      fails++; $display("FAIL fast_emit: pulses=%0d code=%0d len=%0d want 1 8 1", vld1 - vb, last_code1, last_run1); end
    keys1 = '0; scans(3);
    tests++; if (key_down1 !== 1'b0) begin fails++; $display("FAIL fast_release: key_down=%b want 0", key_down1); end
  endtask

  task automatic test_random();
    int expq[$];
    int cb, rb, bb, idx, idx2;
    bit chord;
    cb = codes0.size(); rb = runs0.size(); bb = bad0;
    for (int n = 0; n < 12; n++) begin
      idx   = int'($urandom_range(0, 15));
      chord = ($urandom_range(0, 3) == 0);
      idx2  = (idx + int'($urandom_range(1, 15))) % 16;
      keys0 = (16'(1) << idx) | (chord ? (16'(1) << idx2) : 16'h0);
      if (!chord && model_code(idx) >= 0) expq.push_back(model_code(idx));
      tick(int'($urandom_range(90, 200)));
      keys0 = '0;
      tick(int'($urandom_range(90, 180)));
    end
    tick(60);
    tests++; if (codes0.size() - cb != expq.size()) begin
      fails++; $display("FAIL rand_count: got %0d emissions want %0d", codes0.size() - cb, expq.size()); end
    foreach (expq[k]) begin
      tests++;
      if (codes0.size() <= cb + k || codes0[cb + k] != expq[k]) begin
        fails++; $display("FAIL rand_code[%0d]: got %0d want %0d", k,
                          (codes0.size() > cb + k) ? codes0[cb + k] : -1, expq[k]); end
    end
    for (int k = rb; k < runs0.size(); k++) begin
      tests++; if (runs0[k] != 10) begin fails++; $display("FAIL rand_hold[%0d]: got %0d want 10", k - rb, runs0[k]); end
    end
    tests++; if (bad0 != bb || key_down0 !== 1'b0) begin
      fails++; $display("FAIL rand_tail: bad=%0d key_down=%b want 0 0", bad0 - bb, key_down0); end
  endtask

  task automatic test_reset_mid_emit();
    int vb;
    bit got;
    wait_scan();
    keys0 = 16'h0020;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clock); #1;
      if (cmd_valid0) got = 1'b1;
    end
    tick(3);
    tests++; if (!got || cmd0 !== 4'd5) begin
      fails++; $display("FAIL pre_reset_emit: seen=%0d cmd=%0d want 5", got, cmd0); end
    @(negedge clock); #2 reset = 1'b1;
    #1;
    tests++; if (cmd0 !== 4'b1111 || rows0 !== 4'b1110 || key_down0 !== 1'b0 || cmd_valid0 !== 1'b0) begin
      fails++; $display("FAIL reset_mid_emit: cmd=%b rows=%b key_down=%b valid=%b want 1111 1110 0 0",
                        cmd0, rows0, key_down0, cmd_valid0); end
    keys0 = '0;
    @(negedge clock); reset = 1'b0;
    vb = vld0;
    tick(100);
    tests++; if (vld0 != vb || rows0 === 4'bxxxx) begin
      fails++; $display("FAIL post_reset_quiet: pulses=%0d want 0", vld0 - vb); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghost();
    test_sequence();
    test_boundary();
    test_fast_params();
    test_random();
    test_reset_mid_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
